regfile_seq: RTL and testbench

- Command-driven access master for the per-core register file: drives its read-port and write-port side.
- Accepts one register operation per handshake: read up to two sources, compute, write one destination, return result/status.
- Sits between the core control logic and the register file; it is the sole driver of rpa/rpb/wp/we/din.

---
 rtl/regfile_seq.sv | 171 +++++++++++++++++
 tb/tb_regfile_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// -----------------------------------------------------------------------------
// regfile_seq
//   Command-driven access master for the per-core register file. One command
//   per handshake: read up to two sources, compute, write one destination and
//   return the result with an error flag. It is the only driver of the
//   register file's read-address, write-address and write-data ports.
//
//   Sequence per command: IDLE -> READ -> WRITE -> RESP -> IDLE.
//   A NOP goes from IDLE directly to RESP.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (cmd_ready only in IDLE)
//   cmd_op                  0 NOP 1 MOV 2 ADD 3 SUB 4 AND 5 OR 6 ADDI 7 CLR
//   cmd_dst                 destination register (0 = discard result)
//   cmd_srca / cmd_srcb     source registers (index 0 reads as zero)
//   cmd_imm                 ADDI immediate, zero-extended
//   rsp_valid / rsp_ready   response handshake
//   rsp_data / rsp_err      result and address-error flag
//   rf_rpa / rf_rpb         register file read addresses (nonzero only in READ)
//   rf_douta / rf_doutb     register file combinational read data
//   rf_wp                   register file write address (0 = no write)
//   rf_we                   write data select (1 = rf_din, 0 = clear to zero)
//   rf_din                  register file write data
// -----------------------------------------------------------------------------
module regfile_seq #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int NREG   = 20,
   parameter int RO_REG = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_srca,
   input  logic [AW-1:0] cmd_srcb,
   input  logic [15:0]   cmd_imm,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic [AW-1:0] rf_rpa,
   output logic [AW-1:0] rf_rpb,
   input  logic [DW-1:0] rf_douta,
   input  logic [DW-1:0] rf_doutb,
   output logic [AW-1:0] rf_wp,
   output logic          rf_we,
   output logic [DW-1:0] rf_din
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_MOV  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_ADDI = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [AW-1:0] NREG_A = AW'(NREG);
   localparam logic [AW-1:0] RO_A   = AW'(RO_REG);

   logic [1:0]    state;
   logic [2:0]    op_q;
   logic [AW-1:0] dst_q;
   logic [AW-1:0] srca_q;
   logic [AW-1:0] srcb_q;
   logic [15:0]   imm_q;
   logic [DW-1:0] data_q;
   logic          err_q;

   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic [DW-1:0] result;
   logic          uses_a;
   logic          uses_b;
   logic          src_err;
   logic          dst_err;
   logic          wr_en;

   // Operand selection, ALU and address checks; only meaningful in READ.
   // NOTE: every signal assigned in this always_comb gets a default first so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      opa    = (srca_q == '0) ? '0 : rf_douta;
      opb    = (srcb_q == '0) ? '0 : rf_doutb;
      result = '0;
      uses_a = 1'b0;
      uses_b = 1'b0;
      case (op_q)
         OP_MOV:  begin result = opa;                            uses_a = 1'b1; end
         OP_ADD:  begin result = opa + opb;                      uses_a = 1'b1; uses_b = 1'b1; end
         OP_SUB:  begin result = opa - opb;                      uses_a = 1'b1; uses_b = 1'b1; end
         OP_AND:  begin result = opa & opb;                      uses_a = 1'b1; uses_b = 1'b1; end
         OP_OR:   begin result = opa | opb;                      uses_a = 1'b1; uses_b = 1'b1; end
         OP_ADDI: begin result = opa + {{(DW-16){1'b0}}, imm_q}; uses_a = 1'b1; end
         default: result = '0;  // CLR and NOP produce zero and read nothing
      endcase
      src_err = (uses_a && (srca_q > NREG_A)) || (uses_b && (srcb_q > NREG_A));
      dst_err = (dst_q == RO_A) || (dst_q > NREG_A);
   end

   // NOTE: state registers are updated with non-blocking assignments so every
   // flop samples values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= '0;
         dst_q  <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         imm_q  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  dst_q  <= cmd_dst;
                  srca_q <= cmd_srca;
                  srcb_q <= cmd_srcb;
                  imm_q  <= cmd_imm;
                  if (cmd_op == OP_NOP) begin
                     data_q <= '0;
                     err_q  <= 1'b0;
                     state  <= S_RESP;
                  end else begin
                     state  <= S_READ;
                  end
               end
            end
            S_READ: begin
               // A bad source zeroes the result; a bad destination only
               // suppresses the write and keeps the computed value.
               data_q <= src_err ? '0 : result;
               err_q  <= src_err || dst_err;
               state  <= S_WRITE;
            end
            S_WRITE: state <= S_RESP;
            default: begin
               if (rsp_ready) state <= S_IDLE;
            end
         endcase
      end
   end

   // Gated by rst_n so a reset edge landing in WRITE never commits a write.
   assign wr_en = rst_n && (state == S_WRITE) && !err_q && (dst_q != '0);

   assign cmd_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;

   assign rf_rpa = (state == S_READ) ? srca_q : '0;
   assign rf_rpb = (state == S_READ) ? srcb_q : '0;
   assign rf_wp  = wr_en ? dst_q : '0;
   // CLR uses the register file's clear path (we low) instead of writing zero.
   assign rf_we  = wr_en && (op_q != OP_CLR);
   assign rf_din = (wr_en && (op_q != OP_CLR)) ? data_q : '0;

endmodule

// File: tb/tb_regfile_seq.sv
// -----------------------------------------------------------------------------
// tb_regfile_seq
//   Bench for regfile_seq. Contains a behavioural register file (combinational
//   reads, write or clear on the rising edge, r15 reloaded with the core ID
//   every cycle) and an architectural reference model that executes each
//   command on an array of register values.
// -----------------------------------------------------------------------------
module tb_regfile_seq;

   localparam logic [31:0] CORE_ID = 32'h0000_00C3;
   localparam logic [2:0] NOP = 3'd0, MOV = 3'd1, ADD = 3'd2, SUB = 3'd3,
                          AND_ = 3'd4, OR_ = 3'd5, ADDI = 3'd6, CLR = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [4:0]  cmd_dst, cmd_srca, cmd_srcb;
   logic [15:0] cmd_imm;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [4:0]  rf_rpa, rf_rpb, rf_wp;
   logic [31:0] rf_douta, rf_doutb, rf_din;
   logic        rf_we;

   always #5 clk = ~clk;

   regfile_seq #(.DW(32), .AW(5), .NREG(20), .RO_REG(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rf_rpa(rf_rpa), .rf_rpb(rf_rpb), .rf_douta(rf_douta), .rf_doutb(rf_doutb),
      .rf_wp(rf_wp), .rf_we(rf_we), .rf_din(rf_din)
   );

   // ---------------- behavioural register file ----------------
   logic [31:0] rf_mem [0:31];
   int          wr_count;
   logic [4:0]  last_wp;
   logic        last_we;
   logic [31:0] last_din;

   assign rf_douta = rf_mem[rf_rpa];
   assign rf_doutb = rf_mem[rf_rpb];

   always @(posedge clk) begin
      if (rf_wp != 5'd0) begin
         rf_mem[rf_wp] <= rf_we ? rf_din : 32'd0;
         wr_count = wr_count + 1;
         last_wp  = rf_wp;
         last_we  = rf_we;
         last_din = rf_din;
      end
      rf_mem[15] <= CORE_ID;
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_rf [0:31];

   task automatic model_exec(input logic [2:0] op, input logic [4:0] dst, a, b,
                             input logic [15:0] imm,
                             output logic [31:0] d, output logic e,
                             output logic wr, output logic we);
      logic [31:0] va, vb, res;
      logic need_a, need_b, bad;
      va = (a == 5'd0) ? 32'd0 : ref_rf[a];
      vb = (b == 5'd0) ? 32'd0 : ref_rf[b];
      need_a = (op >= MOV) && (op <= ADDI);
      need_b = (op >= ADD) && (op <= OR_);
      case (op)
         MOV:     res = va;
         ADD:     res = va + vb;
         SUB:     res = va - vb;
         AND_:    res = va & vb;
         OR_:     res = va | vb;
         ADDI:    res = va + {16'd0, imm};
         default: res = 32'd0;
      endcase
      bad = (need_a && a > 5'd20) || (need_b && b > 5'd20);
      if (op == NOP) begin
         d = 32'd0; e = 1'b0; wr = 1'b0; we = 1'b0;
      end else begin
         e  = bad || dst == 5'd15 || dst > 5'd20;
         d  = bad ? 32'd0 : res;
         wr = !e && dst != 5'd0;
         we = (op != CLR);
         if (wr) ref_rf[dst] = res;
      end
   endtask

   // ---------------- checking ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one command with rsp_ready=1; returns response and latency in cycles.
   task automatic do_cmd(input logic [2:0] op, input logic [4:0] dst, a, b,
                         input logic [15:0] imm,
                         output logic [31:0] d, output logic e, output int lat);
      int w;
      @(negedge clk);
      cmd_op = op; cmd_dst = dst; cmd_srca = a; cmd_srcb = b; cmd_imm = imm;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      w = 0;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
      wr_count = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op = 3'($urandom); cmd_dst = 5'($urandom); cmd_srca = 5'($urandom);
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (lat == 1 && op != NOP) begin
            check("read_addr_a", 32'(rf_rpa), 32'(a));
            check("read_addr_b", 32'(rf_rpb), 32'(b));
         end
         if (rsp_valid) break;
      end
      d = rsp_data; e = rsp_err;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  dst, a, b;
      logic [15:0] imm;
      logic [31:0] data;
      logic        err;
      logic        wr;
      logic        we;
   } vec_t;

   vec_t vecs [18];

   task automatic check_cmd(input string tag, input logic [2:0] op, input logic [4:0] dst,
                            input logic [31:0] d, input logic e, input int lat,
                            input logic [31:0] ed, input logic ee, input logic ewr, input logic ewe);
      check({tag, "_data"}, d, ed);
      check({tag, "_err"}, 32'(e), 32'(ee));
      check({tag, "_lat"}, 32'(lat), (op == NOP) ? 32'd1 : 32'd3);
      check({tag, "_nwr"}, 32'(wr_count), ewr ? 32'd1 : 32'd0);
      if (ewr && wr_count == 1) begin
         check({tag, "_wp"}, 32'(last_wp), 32'(dst));
         check({tag, "_we"}, 32'(last_we), 32'(ewe));
         check({tag, "_din"}, last_din, ewe ? ed : 32'd0);
      end
   endtask

   initial begin
      logic [31:0] d, md, hd;
      logic        e, me, mwr, mwe, he;
      logic [31:0] ea_d, eb_d, pre6;
      logic        ea_e, eb_e, tmp_w, tmp_we;
      logic [2:0]  rop;
      logic [4:0]  rdst, ra, rb;
      logic [15:0] rimm;
      int          lat, w;

      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = (i > 20) ? (32'hBAD0_0000 | 32'(i)) : 32'd0;
         ref_rf[i] = rf_mem[i];
      end
      rf_mem[15] = CORE_ID; ref_rf[15] = CORE_ID;
      rf_mem[19] = 32'd1;   ref_rf[19] = 32'd1;
      rf_mem[20] = 32'd4;   ref_rf[20] = 32'd4;

      vecs[0]  = '{ADD,  5'd3,  5'd19, 5'd20, 16'h0,    32'd5,         1'b0, 1'b1, 1'b1};
      vecs[1]  = '{MOV,  5'd0,  5'd3,  5'd0,  16'h0,    32'd5,         1'b0, 1'b0, 1'b1};
      vecs[2]  = '{SUB,  5'd4,  5'd19, 5'd20, 16'h0,    32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{ADDI, 5'd4,  5'd4,  5'd0,  16'h0004, 32'd1,         1'b0, 1'b1, 1'b1};
      vecs[4]  = '{CLR,  5'd20, 5'd0,  5'd0,  16'h0,    32'd0,         1'b0, 1'b1, 1'b0};
      vecs[5]  = '{MOV,  5'd0,  5'd20, 5'd0,  16'h0,    32'd0,         1'b0, 1'b0, 1'b1};
      vecs[6]  = '{MOV,  5'd15, 5'd19, 5'd0,  16'h0,    32'd1,         1'b1, 1'b0, 1'b1};
      vecs[7]  = '{ADD,  5'd2,  5'd25, 5'd19, 16'h0,    32'd0,         1'b1, 1'b0, 1'b1};
      vecs[8]  = '{NOP,  5'd3,  5'd31, 5'd31, 16'hFFFF, 32'd0,         1'b0, 1'b0, 1'b0};
      vecs[9]  = '{AND_, 5'd7,  5'd3,  5'd4,  16'h0,    32'd1,         1'b0, 1'b1, 1'b1};
      vecs[10] = '{MOV,  5'd21, 5'd3,  5'd0,  16'h0,    32'd5,         1'b1, 1'b0, 1'b1};
      vecs[11] = '{MOV,  5'd8,  5'd15, 5'd0,  16'h0,    CORE_ID,       1'b0, 1'b1, 1'b1};
      vecs[12] = '{CLR,  5'd9,  5'd31, 5'd31, 16'h0,    32'd0,         1'b0, 1'b1, 1'b0};
      vecs[13] = '{OR_,  5'd11, 5'd3,  5'd19, 16'h0,    32'd5,         1'b0, 1'b1, 1'b1};
      vecs[14] = '{ADDI, 5'd12, 5'd0,  5'd0,  16'hFFFF, 32'h0000_FFFF, 1'b0, 1'b1, 1'b1};
      vecs[15] = '{SUB,  5'd13, 5'd0,  5'd19, 16'h0,    32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};
      vecs[16] = '{AND_, 5'd14, 5'd3,  5'd22, 16'h0,    32'd0,         1'b1, 1'b0, 1'b1};
      vecs[17] = '{CLR,  5'd15, 5'd0,  5'd0,  16'h0,    32'd0,         1'b1, 1'b0, 1'b0};

      // ---------------- reset ----------------
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0;
      wr_count = 0;
      repeat (3) @(negedge clk);
      check("reset_wp", 32'(rf_wp), 32'd0);
      rst_n = 1'b1;
      #1;
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_rf_we", 32'(rf_we), 32'd0);

      // ---------------- directed table ----------------
      for (int i = 0; i < 18; i++) begin
         do_cmd(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].imm, d, e, lat);
         model_exec(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].imm, md, me, mwr, mwe);
         check_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, d, e, lat,
                   vecs[i].data, vecs[i].err, vecs[i].wr, vecs[i].we);
      end

      // ---------------- randomized against the model ----------------
      for (int i = 0; i < 80; i++) begin
         rop  = 3'($urandom);
         rdst = 5'($urandom_range(0, 23));
         ra   = 5'($urandom_range(0, 23));
         rb   = 5'($urandom_range(0, 23));
         rimm = 16'($urandom);
         do_cmd(rop, rdst, ra, rb, rimm, d, e, lat);
         model_exec(rop, rdst, ra, rb, rimm, md, me, mwr, mwe);
         check_cmd($sformatf("rnd%0d", i), rop, rdst, d, e, lat, md, me, mwr, mwe);
      end

      for (int r = 1; r <= 20; r++)
         if (r != 15) check($sformatf("final_r%0d", r), rf_mem[r], ref_rf[r]);

      // ---------------- response backpressure ----------------
      model_exec(ADD, 5'd10, 5'd19, 5'd3, 16'h0, ea_d, ea_e, tmp_w, tmp_we);
      model_exec(MOV, 5'd0, 5'd10, 5'd0, 16'h0, eb_d, eb_e, tmp_w, tmp_we);
      @(negedge clk);
      cmd_op = ADD; cmd_dst = 5'd10; cmd_srca = 5'd19; cmd_srcb = 5'd3; cmd_imm = '0;
      cmd_valid = 1'b1; rsp_ready = 1'b0; wr_count = 0;
      check("bp_idle_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_op = MOV; cmd_dst = 5'd0; cmd_srca = 5'd10; cmd_srcb = 5'd0;
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp_valid && w < 10);
      check("bp_lat", 32'(w), 32'd3);
      check("bp_data", rsp_data, ea_d);
      check("bp_err", 32'(rsp_err), 32'(ea_e));
      hd = rsp_data; he = rsp_err;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_data", rsp_data, hd);
         check("bp_hold_err", 32'(rsp_err), 32'(he));
         check("bp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_after_hs_ready", 32'(cmd_ready), 32'd1);
      check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
      check("bp_writes", 32'(wr_count), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp_valid && w < 10);
      check("bp_second_lat", 32'(w), 32'd3);
      check("bp_second_data", rsp_data, eb_d);
      @(posedge clk); #1;

      // ---------------- reset during WRITE ----------------
      pre6 = ref_rf[6];
      @(negedge clk);
      cmd_op = ADDI; cmd_dst = 5'd6; cmd_srca = 5'd3; cmd_srcb = 5'd0; cmd_imm = 16'h1234;
      cmd_valid = 1'b1; rsp_ready = 1'b1; wr_count = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);                       // READ
      @(negedge clk);                       // WRITE
      check("rst_write_wp_before", 32'(rf_wp), 32'd6);
      rst_n = 1'b0;
      #1;
      check("rst_write_wp_forced", 32'(rf_wp), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_write_nwr", 32'(wr_count), 32'd0);
      check("rst_write_r6", rf_mem[6], pre6);
      check("rst_write_ready", 32'(cmd_ready), 32'd1);
      check("rst_write_valid", 32'(rsp_valid), 32'd0);
      check("rst_write_data", rsp_data, 32'd0);
      do_cmd(MOV, 5'd0, 5'd6, 5'd0, 16'h0, d, e, lat);
      model_exec(MOV, 5'd0, 5'd6, 5'd0, 16'h0, md, me, mwr, mwe);
      check_cmd("post_rst", MOV, 5'd0, d, e, lat, md, me, mwr, mwe);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
